pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core: turns stage stall requests into a per-stage stall vector, resolves redirects (branch, exception, eret) into a single next-PC command for the PC register, and drives a pipeline flush window on exceptions. It sits beside the datapath. Its stall bit 0 feeds the PC register's stall input, and its redirect outputs override sequential PC increment.

---
 rtl/ctrl_pkg.sv | 13 +
 rtl/stall_watchdog.sv | 17 +
 rtl/pipe_ctrl.sv | 68 ++++++
 tb/tb_pipe_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, stage index and stall vector definitions for pipe_ctrl
package ctrl_pkg;
  typedef enum logic {RUN, FLUSH} state_t;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
endpackage

// File: rtl/stall_watchdog.sv
// stall_watchdog: flags STALL_LIMIT consecutive PC-stall cycles until the stall drops
module stall_watchdog #(
  parameter int STALL_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic timeout
);
  localparam int W = $clog2(STALL_LIMIT + 1);
  logic [W-1:0] cnt;
  // count consecutive stall cycles before this one, saturating so the flag stays sticky
  always_ff @(posedge clk)
    if (!rst || !stall) cnt <= '0;
    else if (cnt != W'(STALL_LIMIT)) cnt <= cnt + 1'b1;
  assign timeout = stall && (cnt >= W'(STALL_LIMIT - 1));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall vector, redirect and flush sequencing; STALL_WATCHDOG_EN adds a stall watchdog
module pipe_ctrl
  import ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_LIMIT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stallreq_id,
  input  logic        i_stallreq_ex,
  input  logic        i_branch_valid,
  input  logic [31:0] i_branch_target,
  input  logic        i_excp_valid,
  input  logic [31:0] i_excp_vector,
  input  logic        i_eret_valid,
  input  logic [31:0] i_epc,
  output logic [5:0]  o_stall,
  output logic        o_flush,
  output logic        o_new_pc_valid,
  output logic [31:0] o_new_pc,
  output logic        o_stall_timeout
);
  state_t     state;
  logic [3:0] cnt;
  logic       any_stall;
  assign any_stall = i_stallreq_ex | i_stallreq_id;
  // stalls are combinational from requests, suppressed during reset and flush
  always_comb
    o_stall = (!rst || state != RUN) ? STALL_NONE :
              i_stallreq_ex ? STALL_EX : i_stallreq_id ? STALL_ID : STALL_NONE;
  // redirect/flush sequencer: exception beats eret, stalls drop a same-cycle branch
  always_ff @(posedge clk)
    if (!rst) begin
      state          <= RUN;
      cnt            <= 4'd0;
      o_flush        <= 1'b0;
      o_new_pc_valid <= 1'b0;
      o_new_pc       <= '0;
    end else if (state == FLUSH) begin
      o_new_pc_valid <= 1'b0;
      o_flush        <= cnt != 4'd0;
      cnt            <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      state          <= cnt == 4'd0 ? RUN : FLUSH;
    end else begin
      o_new_pc_valid <= i_excp_valid | i_eret_valid | (i_branch_valid & ~any_stall);
      o_flush        <= i_excp_valid | i_eret_valid;
      if (i_excp_valid | i_eret_valid) begin
        state <= FLUSH;
        cnt   <= 4'(FLUSH_CYCLES - 1);
      end
      if (i_excp_valid) o_new_pc <= i_excp_vector;
      else if (i_eret_valid) o_new_pc <= i_epc;
      else if (i_branch_valid && !any_stall) o_new_pc <= i_branch_target;
    end
`ifdef STALL_WATCHDOG_EN
  stall_watchdog #(.STALL_LIMIT(STALL_LIMIT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .stall   (o_stall[STG_PC]),
    .timeout (o_stall_timeout)
  );
`else
  logic unused_limit;
  assign unused_limit    = ^STALL_LIMIT;
  assign o_stall_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a flush-window reference model
module tb_pipe_ctrl;
  localparam int FC = 2;
  localparam int LIMIT = 4;
`ifdef STALL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, sid, sex, bv, ev, rv;
  logic [31:0] bt, evec, epc;
  logic [5:0] o_stall;
  logic o_flush, o_new_pc_valid, o_stall_timeout;
  logic [31:0] o_new_pc;
  int checks = 0;
  int failures = 0;
  // reference model: flush window length, pending redirect, stall run length
  int flush_left = 0;
  int run = 0;
  logic m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic [5:0] e_stall;
  logic e_flush, e_to;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_stallreq_id(sid), .i_stallreq_ex(sex),
    .i_branch_valid(bv), .i_branch_target(bt),
    .i_excp_valid(ev), .i_excp_vector(evec),
    .i_eret_valid(rv), .i_epc(epc),
    .o_stall(o_stall), .o_flush(o_flush),
    .o_new_pc_valid(o_new_pc_valid), .o_new_pc(o_new_pc),
    .o_stall_timeout(o_stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic r, input logic s_id, input logic s_ex, input logic b,
                       input logic [31:0] t, input logic e, input logic [31:0] v,
                       input logic er, input logic [31:0] p);
    @(negedge clk);
    rst = r; sid = s_id; sex = s_ex; bv = b; bt = t; ev = e; evec = v; rv = er; epc = p;
    #1;
    e_flush = flush_left > 0;
    e_stall = (!rst || e_flush) ? 6'b000000 : sex ? 6'b001111 : sid ? 6'b000111 : 6'b000000;
    e_to = WD && e_stall[0] && (run + 1 >= LIMIT);
  endtask

  task automatic advance;
    @(posedge clk);
    if (!rst) begin
      flush_left = 0; run = 0; m_valid = 1'b0; m_pc = '0;
    end else begin
      run = e_stall[0] ? run + 1 : 0;
      if (flush_left > 0) begin flush_left--; m_valid = 1'b0; end
      else if (ev) begin m_pc = evec; m_valid = 1'b1; flush_left = FC; end
      else if (rv) begin m_pc = epc; m_valid = 1'b1; flush_left = FC; end
      else if (bv && !sex && !sid) begin m_pc = bt; m_valid = 1'b1; end
      else m_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    apply(0, 1, 1, 1, 32'h400, 1, 32'h180, 1, 32'h2000);
    checks++; if (o_stall !== 6'b0) begin failures++; $display("FAIL rst_stall0 got=%b exp=000000", o_stall); end
    advance;
    apply(0, 1, 1, 1, 32'h400, 1, 32'h180, 1, 32'h2000);
    checks++;
    if ({o_stall, o_flush, o_new_pc_valid, o_new_pc, o_stall_timeout} !== 41'd0) begin
      failures++; $display("FAIL rst_outputs stall=%b flush=%b valid=%b pc=%h to=%b exp all 0",
                           o_stall, o_flush, o_new_pc_valid, o_new_pc, o_stall_timeout);
    end
    advance;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({o_stall, o_flush, o_new_pc_valid} !== 8'd0) begin
      failures++; $display("FAIL rst_release stall=%b flush=%b valid=%b exp 0", o_stall, o_flush, o_new_pc_valid);
    end
    advance;
  endtask

  task automatic test_load_use;
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 0, i == 1, 32'h400, 0, 0, 0, 0);
      checks++; if (o_stall !== 6'b000111) begin failures++; $display("FAIL ld_stall%0d got=%b exp=000111", i, o_stall); end
      checks++; if (o_new_pc_valid !== 1'b0) begin failures++; $display("FAIL ld_valid%0d got=%b exp=0", i, o_new_pc_valid); end
      advance;
    end
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_new_pc_valid !== 1'b0) begin failures++; $display("FAIL ld_branch_dropped got=%b exp=0", o_new_pc_valid); end
    checks++; if (o_stall !== 6'b0) begin failures++; $display("FAIL ld_release got=%b exp=000000", o_stall); end
    advance;
  endtask

  task automatic test_branch;
    apply(1, 0, 0, 1, 32'h100, 0, 0, 0, 0);
    advance;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_new_pc_valid !== 1'b1) begin failures++; $display("FAIL br_valid got=%b exp=1", o_new_pc_valid); end
    checks++; if (o_new_pc !== 32'h100) begin failures++; $display("FAIL br_pc got=%h exp=00000100", o_new_pc); end
    checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL br_flush got=%b exp=0", o_flush); end
    advance;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_new_pc_valid !== 1'b0) begin failures++; $display("FAIL br_pulse got=%b exp=0", o_new_pc_valid); end
    checks++; if (o_new_pc !== 32'h100) begin failures++; $display("FAIL br_hold got=%h exp=00000100", o_new_pc); end
    advance;
  endtask

  task automatic test_excp_stall;
    apply(1, 0, 1, 0, 0, 1, 32'h8000_0180, 0, 0);
    checks++; if (o_stall !== 6'b001111) begin failures++; $display("FAIL ex_stallN got=%b exp=001111", o_stall); end
    advance;
    apply(1, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
    checks++; if (o_new_pc_valid !== 1'b1 || o_new_pc !== 32'h8000_0180) begin
      failures++; $display("FAIL ex_redirect valid=%b pc=%h exp 1/80000180", o_new_pc_valid, o_new_pc); end
    checks++; if (o_flush !== 1'b1 || o_stall !== 6'b0) begin
      failures++; $display("FAIL ex_n1 flush=%b stall=%b exp 1/000000", o_flush, o_stall); end
    advance;
    apply(1, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (o_flush !== 1'b1 || o_stall !== 6'b0 || o_new_pc_valid !== 1'b0) begin
      failures++; $display("FAIL ex_n2 flush=%b stall=%b valid=%b exp 1/000000/0", o_flush, o_stall, o_new_pc_valid); end
    advance;
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_flush !== 1'b0 || o_stall !== 6'b000111) begin
      failures++; $display("FAIL ex_resume flush=%b stall=%b exp 0/000111", o_flush, o_stall); end
    checks++; if (o_new_pc !== 32'h8000_0180 || o_new_pc_valid !== 1'b0) begin
      failures++; $display("FAIL ex_eret_ignored pc=%h valid=%b exp 80000180/0", o_new_pc, o_new_pc_valid); end
    advance;
  endtask

  task automatic test_excp_eret_reset;
    apply(1, 0, 0, 0, 0, 1, 32'h180, 1, 32'h2000);
    advance;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_new_pc !== 32'h180 || o_flush !== 1'b1) begin
      failures++; $display("FAIL ee_priority pc=%h flush=%b exp 00000180/1", o_new_pc, o_flush); end
    advance;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance;
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_flush !== 1'b0 || o_new_pc_valid !== 1'b0 || o_new_pc !== 32'h0) begin
      failures++; $display("FAIL ee_reset_flush flush=%b valid=%b pc=%h exp 0/0/0", o_flush, o_new_pc_valid, o_new_pc); end
    advance;
  endtask

  task automatic test_watchdog;
    for (int i = 0; i < 6; i++) begin
      apply(1, 0, 1, 0, 0, 0, 0, 0, 0);
      checks++; if (o_stall_timeout !== (WD && i >= 3)) begin
        failures++; $display("FAIL wd_cycle%0d got=%b exp=%b", i, o_stall_timeout, WD && i >= 3); end
      advance;
    end
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (o_stall_timeout !== 1'b0) begin failures++; $display("FAIL wd_clear got=%b exp=0", o_stall_timeout); end
    advance;
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(99) >= 2, $urandom_range(99) < 20, $urandom_range(99) < 15,
            $urandom_range(99) < 35, $urandom, $urandom_range(99) < 5, $urandom,
            $urandom_range(99) < 5, $urandom);
      checks++;
      if ({o_stall, o_flush, o_new_pc_valid, o_new_pc, o_stall_timeout} !== {e_stall, e_flush, m_valid, m_pc, e_to}) begin
        failures++;
        $display("FAIL rand%0d got stall=%b flush=%b valid=%b pc=%h to=%b exp stall=%b flush=%b valid=%b pc=%h to=%b",
                 i, o_stall, o_flush, o_new_pc_valid, o_new_pc, o_stall_timeout,
                 e_stall, e_flush, m_valid, m_pc, e_to);
      end
      advance;
    end
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_branch;
    test_excp_stall;
    test_excp_eret_reset;
    test_watchdog;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
